// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch/loader stage.
// The CHECK state only exists when LOAD_CHECKSUM_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef LOAD_CHECKSUM_EN
    ST_CHECK = 2'd2,
`endif
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/instr_ram.sv
// DEPTH x 32 instruction store: one write port, one registered read port (1-cycle latency).
// Read-during-write to the same address returns the old word; read data holds while rd_en is low.
module instr_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_dat
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_fetch_loader.sv
// Fetch stage with program loader: streams words into memory at Load_base, then fetches PC+Offset (1-cycle latency).
// Loader accepts on Load_valid && Load_ready; LOAD_CHECKSUM_EN adds a trailing checksum word and sticky Load_err.
module instr_fetch_loader
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load_start,
  input  logic [31:0]      Load_base,
  input  logic [LEN_W-1:0] Load_len,
  input  logic             Load_valid,
  input  logic [31:0]      Load_data,
  output logic             Load_ready,
  output logic             carregando,
  output logic [31:0]      Offset,
  input  logic [31:0]      PC,
  input  logic             Halt,
  output logic [31:0]      Instr,
  output logic             Instr_valid,
  output logic             Addr_fault,
  output logic             Load_err
);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   count;
  logic               accept, last_word, start;
  logic [31:0]        pa;
  logic               pa_out, fetch;
  logic               instr_zero;
  logic [31:0]        ram_dat;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;

  assign accept    = Load_valid && Load_ready;
  assign last_word = (count == Load_len - LEN_W'(1));
  assign start     = Load_start && (state == ST_IDLE || state == ST_RUN);
  assign pa        = PC + Offset;
  assign pa_out    = (pa >= 32'(DEPTH));
  assign fetch     = (state == ST_RUN) && !Load_start && !Halt && !pa_out;
  assign wr_en     = (state == ST_LOAD) && accept;
  assign wr_addr   = Offset[ADDR_W-1:0] + count[ADDR_W-1:0];
  // Instr is zero after reset and after a faulting fetch; otherwise the RAM's held read word.
  assign Instr     = instr_zero ? NOP_INSTR : ram_dat;

`ifdef LOAD_CHECKSUM_EN
  logic [31:0] sum;
  logic        sum_ok;
  assign sum_ok = ((sum + Load_data) == 32'h0);
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Load_ready = 1'b0;
    carregando = 1'b0;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (Load_start) state_nxt = (Load_len == '0) ? ST_RUN : ST_LOAD;
      end
      ST_LOAD: begin
        Load_ready = 1'b1;
        carregando = 1'b1;
`ifdef LOAD_CHECKSUM_EN
        if (accept && last_word) state_nxt = ST_CHECK;
`else
        if (accept && last_word) state_nxt = ST_RUN;
`endif
      end
`ifdef LOAD_CHECKSUM_EN
      ST_CHECK: begin
        Load_ready = 1'b1;
        carregando = 1'b1;
        if (accept) state_nxt = sum_ok ? ST_RUN : ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Offset      <= '0;
      count       <= '0;
      instr_zero  <= 1'b1;
      Instr_valid <= 1'b0;
      Addr_fault  <= 1'b0;
    end else begin
      if (start) begin
        Offset <= Load_base;
        count  <= '0;
      end else if (wr_en) begin
        count  <= count + LEN_W'(1);
      end

      // A new Load_start in RUN takes priority over fetching and leaves Instr unchanged.
      if (state == ST_RUN && !Load_start) begin
        if (Halt) begin
          Instr_valid <= 1'b0;
        end else if (pa_out) begin
          instr_zero  <= 1'b1;
          Instr_valid <= 1'b0;
          Addr_fault  <= 1'b1;
        end else begin
          instr_zero  <= 1'b0;
          Instr_valid <= 1'b1;
          Addr_fault  <= 1'b0;
        end
      end else begin
        Instr_valid <= 1'b0;
        Addr_fault  <= 1'b0;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sum      <= '0;
      Load_err <= 1'b0;
    end else if (start) begin
      sum      <= '0;
      Load_err <= 1'b0;
    end else begin
      if (wr_en) sum <= sum + Load_data;
      if (state == ST_CHECK && accept && !sum_ok) Load_err <= 1'b1;
    end
  end
`else
  assign Load_err = 1'b0;
`endif

  instr_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (Clock),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_dat (Load_data),
    .rd_en  (fetch),
    .rd_addr(pa[ADDR_W-1:0]),
    .rd_dat (ram_dat)
  );

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Directed bench for instr_fetch_loader: load, fetch, backpressure, faults, halt, reset mid-load, checksum.
module tb_instr_fetch_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Load_start;
  logic [31:0] Load_base;
  logic [15:0] Load_len;
  logic        Load_valid;
  logic [31:0] Load_data;
  logic        Load_ready;
  logic        carregando;
  logic [31:0] Offset;
  logic [31:0] PC;
  logic        Halt;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic        Addr_fault;
  logic        Load_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] W_A = 32'hAAAA_0001;
  localparam logic [31:0] W_B = 32'hBBBB_0002;
  localparam logic [31:0] W_C = 32'hCCCC_0003;
  localparam logic [31:0] W_D = 32'hDDDD_0004;
  localparam logic [31:0] W_E = 32'hEEEE_0005;
  localparam logic [31:0] W_F = 32'hFFFF_0006;
  localparam logic [31:0] W_G = 32'h1234_5678;
  localparam logic [31:0] W_H = 32'h9ABC_DEF0;

  instr_fetch_loader dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Load_start (Load_start),
    .Load_base  (Load_base),
    .Load_len   (Load_len),
    .Load_valid (Load_valid),
    .Load_data  (Load_data),
    .Load_ready (Load_ready),
    .carregando (carregando),
    .Offset     (Offset),
    .PC         (PC),
    .Halt       (Halt),
    .Instr      (Instr),
    .Instr_valid(Instr_valid),
    .Addr_fault (Addr_fault),
    .Load_err   (Load_err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_load(input logic [31:0] base, input logic [15:0] len);
    Load_start = 1'b1;
    Load_base  = base;
    Load_len   = len;
    tick();
    Load_start = 1'b0;
  endtask

  task automatic push(input logic vld, input logic [31:0] w);
    Load_valid = vld;
    Load_data  = w;
    tick();
    Load_valid = 1'b0;
  endtask

  task automatic fetch_at(input logic [31:0] pc);
    PC = pc;
    tick();
  endtask

  initial begin
    logic [4:0]  bp_vld;
    logic [31:0] bp_dat [5];
    Reset = 1'b0; Load_start = 1'b0; Load_base = '0; Load_len = '0;
    Load_valid = 1'b0; Load_data = '0; PC = '0; Halt = 1'b0;
    #1;
    chk("rst_carregando", {31'b0, carregando}, 32'd0);
    chk("rst_ready",      {31'b0, Load_ready}, 32'd0);
    chk("rst_offset",     Offset, 32'd0);
    chk("rst_instr",      Instr, 32'd0);
    chk("rst_ivalid",     {31'b0, Instr_valid}, 32'd0);
    chk("rst_fault",      {31'b0, Addr_fault}, 32'd0);
    chk("rst_err",        {31'b0, Load_err}, 32'd0);
    tick();
    Reset = 1'b1;
    tick();

    // Basic load of A,B,C at 0x10
    start_load(32'h10, 16'd3);
    chk("ld_carregando0", {31'b0, carregando}, 32'd1);
    chk("ld_ready0",      {31'b0, Load_ready}, 32'd1);
    chk("ld_offset",      Offset, 32'h10);
    PC = 32'd1;
    push(1'b1, W_A);
    chk("ld_carregando1", {31'b0, carregando}, 32'd1);
    push(1'b1, W_B);
    chk("ld_carregando2", {31'b0, carregando}, 32'd1);
    push(1'b1, W_C);
    chk("ld_carregando_end", {31'b0, carregando}, 32'd0);
    chk("ld_ready_end",      {31'b0, Load_ready}, 32'd0);
    chk("run_entry_ivalid",  {31'b0, Instr_valid}, 32'd0);
    tick();
    chk("fetch_b",        Instr, W_B);
    chk("fetch_b_valid",  {31'b0, Instr_valid}, 32'd1);
    chk("fetch_b_fault",  {31'b0, Addr_fault}, 32'd0);
    fetch_at(32'd0);
    chk("fetch_a", Instr, W_A);
    fetch_at(32'd2);
    chk("fetch_c", Instr, W_C);

    // Halt: Instr holds while PC moves, resumes one cycle after release
    Halt = 1'b1;
    fetch_at(32'd0);
    chk("halt1_instr",  Instr, W_C);
    chk("halt1_valid",  {31'b0, Instr_valid}, 32'd0);
    fetch_at(32'd1);
    chk("halt2_instr",  Instr, W_C);
    chk("halt2_valid",  {31'b0, Instr_valid}, 32'd0);
    Halt = 1'b0;
    tick();
    chk("unhalt_instr", Instr, W_B);
    chk("unhalt_valid", {31'b0, Instr_valid}, 32'd1);

    // Reload from RUN at 0x40 with gapped Load_valid
    start_load(32'h40, 16'd3);
    chk("bp_carregando", {31'b0, carregando}, 32'd1);
    chk("bp_ivalid",     {31'b0, Instr_valid}, 32'd0);
    chk("bp_offset",     Offset, 32'h40);
    bp_vld = 5'b10101;
    bp_dat[0] = W_D; bp_dat[1] = 32'hBAD0_BAD0; bp_dat[2] = W_E;
    bp_dat[3] = 32'hBAD1_BAD1; bp_dat[4] = W_F;
    for (int i = 0; i < 5; i++) begin
      push(bp_vld[i], bp_dat[i]);
      if (i == 3) chk("bp_still_loading", {31'b0, carregando}, 32'd1);
    end
    chk("bp_run_after_3rd", {31'b0, carregando}, 32'd0);
    fetch_at(32'd0);
    chk("bp_fetch_d", Instr, W_D);
    fetch_at(32'd1);
    chk("bp_fetch_e", Instr, W_E);
    fetch_at(32'd2);
    chk("bp_fetch_f", Instr, W_F);
    // Negative PC wraps back onto the earlier program at 0x10
    fetch_at(32'hFFFF_FFD0);
    chk("wrap_fetch_a", Instr, W_A);
    fetch_at(32'hFFFF_FFD1);
    chk("wrap_fetch_b", Instr, W_B);

    // Zero-length load goes straight to RUN; then out-of-range fetches
    start_load(32'hF0, 16'd0);
    chk("len0_carregando", {31'b0, carregando}, 32'd0);
    chk("len0_offset",     Offset, 32'hF0);
    fetch_at(32'h20);
    chk("oor_fault",  {31'b0, Addr_fault}, 32'd1);
    chk("oor_instr",  Instr, 32'd0);
    chk("oor_valid",  {31'b0, Instr_valid}, 32'd0);
    fetch_at(32'hFFFF_FF50);
    chk("inrange_instr", Instr, W_D);
    chk("inrange_fault", {31'b0, Addr_fault}, 32'd0);
    fetch_at(32'h10);
    chk("edge_256_fault", {31'b0, Addr_fault}, 32'd1);
    chk("edge_256_instr", Instr, 32'd0);

    // Reset mid-load: two of four words written, then reset
    start_load(32'h80, 16'd4);
    push(1'b1, W_G);
    push(1'b1, W_H);
    Reset = 1'b0;
    #1;
    chk("mid_rst_carregando", {31'b0, carregando}, 32'd0);
    chk("mid_rst_ready",      {31'b0, Load_ready}, 32'd0);
    chk("mid_rst_offset",     Offset, 32'd0);
    chk("mid_rst_instr",      Instr, 32'd0);
    chk("mid_rst_valid",      {31'b0, Instr_valid}, 32'd0);
    chk("mid_rst_fault",      {31'b0, Addr_fault}, 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    start_load(32'h0, 16'd0);
    fetch_at(32'h80);
    chk("kept_g", Instr, W_G);
    fetch_at(32'h81);
    chk("kept_h", Instr, W_H);

`ifdef LOAD_CHECKSUM_EN
    start_load(32'h20, 16'd2);
    push(1'b1, 32'd1);
    push(1'b1, 32'd2);
    chk("cs_check_state", {31'b0, carregando}, 32'd1);
    push(1'b1, 32'hFFFF_FFFD);
    chk("cs_ok_run",  {31'b0, carregando}, 32'd0);
    chk("cs_ok_err",  {31'b0, Load_err}, 32'd0);
    fetch_at(32'd1);
    chk("cs_ok_fetch", Instr, 32'd2);
    chk("cs_ok_valid", {31'b0, Instr_valid}, 32'd1);
    start_load(32'h20, 16'd2);
    push(1'b1, 32'd1);
    push(1'b1, 32'd2);
    push(1'b1, 32'd0);
    chk("cs_bad_err",  {31'b0, Load_err}, 32'd1);
    chk("cs_bad_carr", {31'b0, carregando}, 32'd0);
    fetch_at(32'd0);
    chk("cs_bad_idle_valid", {31'b0, Instr_valid}, 32'd0);
    chk("cs_err_sticky", {31'b0, Load_err}, 32'd1);
    start_load(32'h0, 16'd0);
    chk("cs_err_cleared", {31'b0, Load_err}, 32'd0);
`else
    chk("no_cs_err", {31'b0, Load_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
